iob_ptfloat_unpack: RTL
=======================

IOB_PTFLOAT_UNPACK -- requirements
Module: iob_ptfloat_unpack

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the packed word width.
REQ-002 The block SHALL have parameter EW_W, default 4, meaning the exponent-width field width at the word LSBs.
REQ-003 The block SHALL take widths EXP_MAX_W, MAN_MAX_W, F_MAX_W (=DATA_W-EW_W) and EXP_MIN from iob_ptfloat_defs.vh, with MAN_MAX_W = F_MAX_W+1.
REQ-004 The block SHALL have port clk_i, input, 1, the single clock.
REQ-005 The block SHALL have port arst_n_i, input, 1, reset, asynchronous and active-low.
REQ-006 The block SHALL have port cke_i, input, 1, clock enable; all registers hold when low.
REQ-007 The block SHALL have port start_i, input, 1, input word valid this cycle.
REQ-008 The block SHALL have port data_i, input, DATA_W, packed word {F field[F_MAX_W-1:0], ew[EW_W-1:0]}.
REQ-009 The block SHALL have port done_o, output, 1, the output fields are valid.
REQ-010 The block SHALL have port exp_o, output, EXP_MAX_W+2, signed decoded exponent.
REQ-011 The block SHALL have port man_o, output, MAN_MAX_W, two's-complement mantissa {sign, hidden, fraction}.
REQ-012 The block SHALL have port ew_err_o, output, 1, ew field exceeds EXP_MAX_W-1.

Function
REQ-013 The block SHALL be a 2-stage pipeline: done_o SHALL equal start_i delayed by exactly 2 cke_i-qualified cycles, with no backpressure.
REQ-014 The block SHALL accept a new word every enabled cycle, with independent words in flight in both stages.
REQ-015 Stage 1 SHALL register ew = data_i[EW_W-1:0], the exponent field e = F >> (F_MAX_W-ew) sign-extended from bit ew-1, the aligned fraction fa = (F << ew) truncated to F_MAX_W bits, and ew_err.
REQ-016 When ew = 0, e SHALL be 0 and fa SHALL equal F.
REQ-017 Stage 2 SHALL drive exp_o = e+1 when e < 0, and exp_o = e when e >= 0, so that it inverts the packer's negative-exponent bias.
REQ-018 Stage 2 SHALL drive man_o = {fa[F_MAX_W-1], ~fa[F_MAX_W-1], fa[F_MAX_W-2:0]}; fraction LSBs below the stored field are zero.
REQ-019 When ew > EXP_MAX_W-1, ew_err_o SHALL be 1 with done_o, exp_o SHALL be EXP_MIN sign-extended, and man_o SHALL be 0.
REQ-020 exp_o, man_o and ew_err_o SHALL hold their last values between done pulses; consumers sample only when done_o = 1.
REQ-021 When cke_i = 0, no stage SHALL advance, and done_o SHALL hold its current value.
REQ-022 Round trip: for in-range normal values, unpack(pack(exp, man)) SHALL return exp and man truncated to the stored fraction bits.

Reset
REQ-023 When arst_n_i = 0, all registers SHALL clear asynchronously: done_o=0, exp_o=0, man_o=0, ew_err_o=0.
REQ-024 A reset asserted mid-operation SHALL discard both in-flight words, with no done pulse after release.
REQ-025 The first done_o after reset release SHALL occur no earlier than 2 enabled cycles after the first start_i.

Structure
REQ-026 The width macros and F_MAX_W SHALL stay in iob_ptfloat_defs.vh; no new package is created.
REQ-027 Pipeline registers SHALL be iob_reg instances, with their reset mapped from arst_n_i inversion at this module boundary only.
REQ-028 The field extraction, sign-extension and bias correction SHALL live in one combinational sub-module, iob_ptfloat_exp_decode (inputs F, ew; outputs e, ew_err).

Verification
REQ-029 data_i=0x40000003 with start_i -> after 2 cycles: done_o=1, exp_o=2, man_o=29'h08000000, ew_err_o=0.
REQ-030 data_i=0xC0000003 (e=-2) -> exp_o=-1, man_o=29'h08000000.
REQ-031 data_i=0x80000000 (ew=0, sign set) -> exp_o=0, man_o=29'h10000000 (sign=1, hidden=0).
REQ-032 data_i with ew=15 (>EXP_MAX_W-1) -> ew_err_o=1, man_o=0, exp_o=EXP_MIN.
REQ-033 Back-to-back starts on 3 cycles with cke_i low for one middle cycle -> three done pulses in order, the gap preserved, each result matching its own input.
REQ-034 arst_n_i low for 1 cycle with 2 words in flight -> no done_o after release, all outputs 0.
REQ-035 A random round trip of 1000 in-range vectors through iob_ptfloat_pack then this block -> exp and truncated man match.

Source files
------------

// File: rtl/iob_ptfloat_defs.vh
// Width macros shared by the ptfloat pack/unpack blocks.
// They expand in terms of the enclosing module's DATA_W and EW_W parameters.
`ifndef IOB_PTFLOAT_DEFS_VH
`define IOB_PTFLOAT_DEFS_VH
`define F_MAX_W   (DATA_W-EW_W)
`define MAN_MAX_W (`F_MAX_W+1)
`define EXP_MAX_W ((2**EW_W)-1)
`define EXP_MIN   (-(2**(`EXP_MAX_W-1)))
`endif

// File: rtl/iob_ptfloat_exp_decode.sv
// Pulls the ew-bit exponent off the top of the F field, sign-extends it and
// undoes the packer's bias, which stores negative exponents one lower.
`include "iob_ptfloat_defs.vh"
module iob_ptfloat_exp_decode #(
    parameter int DATA_W = 32,
    parameter int EW_W   = 4
) (
    input  logic        [`F_MAX_W-1:0]   f_i,
    input  logic        [EW_W-1:0]       ew_i,
    output logic signed [`EXP_MAX_W+1:0] e_o,
    output logic                         ew_err_o
);
    localparam int F_MAX_W   = `F_MAX_W;
    localparam int EXP_MAX_W = `EXP_MAX_W;
    localparam int EXP_W     = EXP_MAX_W + 2;

    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] mask;
    logic             sign;

    always_comb begin
        // ew = 0 shifts the whole field out, leaving e = 0
        e    = EXP_W'(f_i >> (F_MAX_W - int'(ew_i)));
        mask = {EXP_W{1'b1}} << ew_i;
        sign = (ew_i != '0) && e[ew_i - 1'b1];
        if (sign) e = (e | mask) + EXP_W'(1);
        e_o      = e;
        ew_err_o = (int'(ew_i) > EXP_MAX_W - 1);
    end
endmodule

// File: rtl/iob_reg.sv
// Generic enabled register with an active-high asynchronous reset.
module iob_reg #(
    parameter int                DATA_W  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) data_q <= RST_VAL;
        else if (cke_i) data_q <= data_i;
    end

    assign data_o = data_q;
endmodule

// File: rtl/iob_ptfloat_unpack.sv
// Two-stage unpacker: {F, ew} word -> signed exponent and two's-complement
// mantissa with restored hidden bit. Outputs hold between done pulses.
`include "iob_ptfloat_defs.vh"
module iob_ptfloat_unpack #(
    parameter int DATA_W = 32,
    parameter int EW_W   = 4
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic                   cke_i,
    input  logic                   start_i,
    input  logic [DATA_W-1:0]      data_i,
    output logic                   done_o,
    output logic [`EXP_MAX_W+1:0]  exp_o,
    output logic [`MAN_MAX_W-1:0]  man_o,
    output logic                   ew_err_o
);
    localparam int F_MAX_W   = `F_MAX_W;
    localparam int MAN_MAX_W = `MAN_MAX_W;
    localparam int EXP_W     = `EXP_MAX_W + 2;
    localparam logic [EXP_W-1:0] EXP_MIN_X = EXP_W'(`EXP_MIN);

    typedef struct packed {
        logic               err;
        logic [EXP_W-1:0]   e;
        logic [F_MAX_W-1:0] fa;
    } s1_t;

    typedef struct packed {
        logic                 err;
        logic [EXP_W-1:0]     exp;
        logic [MAN_MAX_W-1:0] man;
    } s2_t;

    logic                      arst;
    logic [F_MAX_W-1:0]        f;
    logic [EW_W-1:0]           ew;
    logic signed [EXP_W-1:0]   e_dec;
    logic                      err_dec;
    logic [1:0]                vld_d, vld_q;
    s1_t                       s1_d, s1_q;
    s2_t                       s2_d, s2_q;

    assign arst = ~arst_n_i;
    assign f    = data_i[DATA_W-1:EW_W];
    assign ew   = data_i[EW_W-1:0];

    iob_ptfloat_exp_decode #(.DATA_W(DATA_W), .EW_W(EW_W)) u_dec (
        .f_i      (f),
        .ew_i     (ew),
        .e_o      (e_dec),
        .ew_err_o (err_dec)
    );

    always_comb begin
        vld_d = {vld_q[0], start_i};
        s1_d  = s1_q;
        if (start_i) begin
            s1_d.err = err_dec;
            s1_d.e   = e_dec;
            s1_d.fa  = f << ew;
        end
        // stage 2 only loads on a valid word so results persist for consumers
        s2_d = s2_q;
        if (vld_q[0]) begin
            s2_d.err = s1_q.err;
            if (s1_q.err) begin
                s2_d.exp = EXP_MIN_X;
                s2_d.man = '0;
            end else begin
                s2_d.exp = s1_q.e;
                s2_d.man = {s1_q.fa[F_MAX_W-1], ~s1_q.fa[F_MAX_W-1], s1_q.fa[F_MAX_W-2:0]};
            end
        end
    end

    iob_reg #(.DATA_W(2)) u_vld_reg (
        .clk_i(clk_i), .arst_i(arst), .cke_i(cke_i), .data_i(vld_d), .data_o(vld_q)
    );

    iob_reg #(.DATA_W($bits(s1_t))) u_s1_reg (
        .clk_i(clk_i), .arst_i(arst), .cke_i(cke_i), .data_i(s1_d), .data_o(s1_q)
    );

    iob_reg #(.DATA_W($bits(s2_t))) u_s2_reg (
        .clk_i(clk_i), .arst_i(arst), .cke_i(cke_i), .data_i(s2_d), .data_o(s2_q)
    );

    assign done_o   = vld_q[1];
    assign exp_o    = s2_q.exp;
    assign man_o    = s2_q.man;
    assign ew_err_o = s2_q.err;
endmodule
